// File: rtl/fpu_normalize_pkg.sv
// -----------------------------------------------------------------------------
// fpu_normalize_pkg
//   Shared types for the FPU add/sub normalizer back end: the Align_in record
//   coming from the aligner, the packed Float32 result, the normalizer state
//   encoding and the registered output bundle (result plus exception flags).
// -----------------------------------------------------------------------------
package fpu_normalize_pkg;

    localparam int EXP_W   = 8;                    // exponent width
    localparam int MNT_W   = 25;                   // [24]=carry, [23]=hidden, [22:0]=fraction
    localparam int FRAC_W  = MNT_W - 2;            // stored fraction width
    localparam int ALIGN_W = 2 + 1 + EXP_W + MNT_W; // {op, flip, sign, exp, mnt}

    localparam logic [EXP_W-1:0] EXP_MAX = '1;     // inf/NaN exponent
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_MAX - 1'b1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float32_t;

    typedef struct packed {
        logic              op;
        logic              flip;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MNT_W-1:0]  mnt;
    } align_in_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT,
        ST_ROUND,
        ST_DONE
    } norm_state_e;

    typedef struct packed {
        float32_t f;
        logic     ovf;
        logic     unf;
    } norm_out_t;

    function automatic norm_out_t make_out(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [FRAC_W-1:0] frac,
        input logic              ovf,
        input logic              unf
    );
        norm_out_t o;
        o.f.sign = sign;
        o.f.exp  = exp;
        o.f.frac = frac;
        o.ovf    = ovf;
        o.unf    = unf;
        return o;
    endfunction

endpackage

// File: rtl/fpu_normalize_if.sv
// -----------------------------------------------------------------------------
// fpu_normalize_if
//   Start/done handshake between the FPU controller and the normalizer.
//   start     : request, sampled by the normalizer only while idle
//   in_align  : Align_in {op, flip, sign, exp, mnt}, sampled with start
//   result    : packed Float32, held until the next done
//   done      : one-cycle pulse, result and flags valid
//   busy      : normalizer is not idle (drives the FPU stall hazard)
//   overflow  : exponent saturated to infinity, held like result
//   underflow : result flushed to zero, held like result
// Modports: master = controller side, slave = normalizer side.
// -----------------------------------------------------------------------------
interface fpu_normalize_if;
    import fpu_normalize_pkg::*;

    logic               start;
    logic [ALIGN_W-1:0] in_align;
    logic [31:0]        result;
    logic               done;
    logic               busy;
    logic               overflow;
    logic               underflow;

    modport master (
        output start, in_align,
        input  result, done, busy, overflow, underflow
    );

    modport slave (
        input  start, in_align,
        output result, done, busy, overflow, underflow
    );

endinterface

// File: rtl/fpu_normalize.sv
// -----------------------------------------------------------------------------
// fpu_normalize
//   Back end of the FPU add/sub path. Takes the aligned sum (sign, exponent,
//   25-bit mantissa with carry and hidden bit), resolves carry, zero,
//   inf/NaN pass-through and exponent overflow/underflow, then normalizes by
//   shifting left one bit per cycle and returns a packed Float32.
//   Flow: IDLE -> CHECK -> {SHIFT}* -> [ROUND] -> DONE -> IDLE.
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fpu_normalize_if.slave (start, in_align, result, done, busy,
//           overflow, underflow)
//
// Configuration
//   FPU_NORM_ROUND_EN : adds a ROUND state after normalization that rounds
//   on the guard bit, ties to even (no sticky). Undefined: the guard bit is
//   discarded (truncation) and normalized results arrive one cycle earlier.
// -----------------------------------------------------------------------------
module fpu_normalize
    import fpu_normalize_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    fpu_normalize_if.slave bus
);

    norm_state_e      state_q, state_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [MNT_W-1:0] mnt_q, mnt_d;
    logic [1:0]       opflip_unused_q, opflip_unused_d; // op/flip kept for debug only
    norm_out_t        pend_q, pend_d;                   // result being built
    norm_out_t        out_q, out_d;                     // result presented on the bus
    logic             done_q, done_d;
    logic             norm_ready;                       // mantissa is 1.xxx this cycle
    align_in_t        align;

`ifdef FPU_NORM_ROUND_EN
    logic              guard_q, guard_d;
    logic              rnd_carry;
    logic [FRAC_W-1:0] rnd_frac;
`endif

    assign align = align_in_t'(bus.in_align);

    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        sign_d          = sign_q;
        exp_d           = exp_q;
        mnt_d           = mnt_q;
        opflip_unused_d = opflip_unused_q;
        pend_d          = pend_q;
        out_d           = out_q;
        done_d          = 1'b0;
        norm_ready      = 1'b0;
`ifdef FPU_NORM_ROUND_EN
        guard_d         = guard_q;
        rnd_carry       = 1'b0;
        rnd_frac        = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    opflip_unused_d = {align.op, align.flip};
                    sign_d          = align.sign;
                    exp_d           = align.exp;
                    mnt_d           = align.mnt;
                    state_d         = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (exp_q == EXP_MAX) begin
                    pend_d  = make_out(sign_q, EXP_MAX, mnt_q[FRAC_W-1:0], 1'b0, 1'b0);
                    state_d = ST_DONE;
                end else if (mnt_q == '0) begin
                    pend_d  = make_out(sign_q, '0, '0, 1'b0, 1'b0);
                    state_d = ST_DONE;
                end else if (exp_q == '0) begin
                    pend_d  = make_out(sign_q, '0, '0, 1'b0, 1'b1);
                    state_d = ST_DONE;
                end else if (mnt_q[MNT_W-1]) begin
                    // Carry out of the adder: renormalize right by one. The
                    // overflow test uses the old exponent so exp never wraps.
                    if (exp_q == EXP_TOP) begin
                        pend_d  = make_out(sign_q, EXP_MAX, '0, 1'b1, 1'b0);
                        state_d = ST_DONE;
                    end else begin
                        // NOTE: blocking assignments here so norm_ready and the
                        // exit path below see the updated mnt_d/exp_d values.
                        mnt_d      = mnt_q >> 1;
                        exp_d      = exp_q + 1'b1;
                        norm_ready = 1'b1;
`ifdef FPU_NORM_ROUND_EN
                        guard_d    = mnt_q[0];
`endif
                    end
                end else if (mnt_q[MNT_W-2]) begin
                    norm_ready = 1'b1;
`ifdef FPU_NORM_ROUND_EN
                    guard_d    = 1'b0;
`endif
                end else begin
                    state_d = ST_SHIFT;
`ifdef FPU_NORM_ROUND_EN
                    guard_d = 1'b0;
`endif
                end
            end

            ST_SHIFT: begin
                // Hidden bit still clear; one more shift would need exp 0,
                // which is the denormal range this unit flushes.
                if (exp_q == EXP_W'(1)) begin
                    pend_d  = make_out(sign_q, '0, '0, 1'b0, 1'b1);
                    state_d = ST_DONE;
                end else begin
                    mnt_d = {mnt_q[MNT_W-2:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                    if (mnt_d[MNT_W-2]) begin
                        norm_ready = 1'b1;
                    end
                end
            end

`ifdef FPU_NORM_ROUND_EN
            ST_ROUND: begin
                // Hidden bit is 1 here, so a carry out of the fraction means
                // the mantissa became 10.000..: renormalize to 1.0, exp+1.
                {rnd_carry, rnd_frac} = {1'b0, mnt_q[FRAC_W-1:0]}
                                      + {{FRAC_W{1'b0}}, guard_q & mnt_q[0]};
                if (!rnd_carry) begin
                    pend_d = make_out(sign_q, exp_q, rnd_frac, 1'b0, 1'b0);
                end else if (exp_q == EXP_TOP) begin
                    pend_d = make_out(sign_q, EXP_MAX, '0, 1'b1, 1'b0);
                end else begin
                    pend_d = make_out(sign_q, exp_q + 1'b1, '0, 1'b0, 1'b0);
                end
                state_d = ST_DONE;
            end
`endif

            ST_DONE: begin
                out_d   = pend_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        if (norm_ready) begin
`ifdef FPU_NORM_ROUND_EN
            state_d = ST_ROUND;
`else
            pend_d  = make_out(sign_q, exp_d, mnt_d[FRAC_W-1:0], 1'b0, 1'b0);
            state_d = ST_DONE;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            sign_q          <= 1'b0;
            exp_q           <= '0;
            mnt_q           <= '0;
            opflip_unused_q <= '0;
            pend_q          <= '0;
            out_q           <= '0;
            done_q          <= 1'b0;
`ifdef FPU_NORM_ROUND_EN
            guard_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            sign_q          <= sign_d;
            exp_q           <= exp_d;
            mnt_q           <= mnt_d;
            opflip_unused_q <= opflip_unused_d;
            pend_q          <= pend_d;
            out_q           <= out_d;
            done_q          <= done_d;
`ifdef FPU_NORM_ROUND_EN
            guard_q         <= guard_d;
`endif
        end
    end

    assign bus.result    = out_q.f;
    assign bus.overflow  = out_q.ovf;
    assign bus.underflow = out_q.unf;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_normalize.sv
// -----------------------------------------------------------------------------
// tb_fpu_normalize
//   Self-checking bench for fpu_normalize. A vector table drives one
//   operation at a time; expected results go into a scoreboard queue when
//   start is driven and are popped by a monitor when done pulses. Latency,
//   busy behaviour and the single-cycle done pulse are checked per vector.
//   Hand-written sequences cover start-while-busy and reset mid-operation.
//   Expectations follow FPU_NORM_ROUND_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_fpu_normalize;
    import fpu_normalize_pkg::*;

`ifdef FPU_NORM_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mnt;
        logic [31:0] res;     // truncating build
        logic [31:0] res_r;   // rounding build
        logic        ovf;
        logic        ovf_r;
        logic        unf;
        int          lat;     // truncating build, edges from start to done
        bit          norm;    // goes through the normal exit (+1 with rounding)
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk;
    logic rst_n;

    fpu_normalize_if bus ();

    fpu_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp;
    int   n_fail;
    int   done_cnt;
    exp_t sb[$];
    vec_t vecs[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending op");
            end else begin
                mon_e = sb.pop_front();
                check("result",    bus.result,           mon_e.res);
                check("overflow",  32'(bus.overflow),    32'(mon_e.ovf));
                check("underflow", 32'(bus.underflow),   32'(mon_e.unf));
            end
        end
    end

    task automatic add_vec(input string name, input logic s, input logic [7:0] e,
                           input logic [24:0] m, input logic [31:0] res,
                           input logic [31:0] res_r, input logic ovf,
                           input logic ovf_r, input logic unf, input int lat,
                           input bit norm);
        vec_t v;
        v.name = name; v.sign = s; v.exp = e; v.mnt = m;
        v.res = res; v.res_r = res_r; v.ovf = ovf; v.ovf_r = ovf_r;
        v.unf = unf; v.lat = lat; v.norm = norm;
        vecs.push_back(v);
    endtask

    // Drive one operation and track it to completion. With poke set, a second
    // start (different operand) is raised while the first op is still busy.
    task automatic run_op(input vec_t v, input bit poke);
        exp_t       e;
        int         lat_req;
        int         got;
        int         busy_low;
        logic       busy_at_done;
        logic [1:0] opf;

        e.res   = ROUND_EN ? v.res_r : v.res;
        e.ovf   = ROUND_EN ? v.ovf_r : v.ovf;
        e.unf   = v.unf;
        lat_req = v.lat + ((ROUND_EN && v.norm) ? 1 : 0);
        opf     = 2'($urandom_range(0, 3));

        @(negedge clk);
        bus.in_align = {opf, v.sign, v.exp, v.mnt};
        bus.start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);

        got          = -1;
        busy_low     = 0;
        busy_at_done = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) bus.start = 1'b0;
            if (poke && c == 1) begin
                bus.in_align = {2'b00, 1'b1, 8'h40, 25'h0};
                bus.start    = 1'b1;
            end
            if (poke && c == 3) bus.start = 1'b0;
            if (bus.done) begin
                got          = c;
                busy_at_done = bus.busy;
                break;
            end
            if (!bus.busy) busy_low++;
        end
        bus.start = 1'b0;

        if (got < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in 100 cycles required done", v.name);
            sb.delete();
        end else begin
            check({v.name, "_latency"},   32'(got),          32'(lat_req));
            check({v.name, "_busy_low"},  32'(busy_low),     32'd0);
            check({v.name, "_busy_done"}, 32'(busy_at_done), 32'd0);
            @(negedge clk);
            check({v.name, "_done_pulse"}, 32'(bus.done),    32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cnt_before;
        vec_t v;

        n_cmp        = 0;
        n_fail       = 0;
        done_cnt     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_align = '0;

        //        name            s  exp    mnt          res(trunc)    res(round)    ovf   ovf_r unf   lat norm
        add_vec("norm_one",      0, 8'h7F, 25'h0800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 2,  1);
        add_vec("carry",         0, 8'h7F, 25'h1000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 2,  1);
        add_vec("carry_ovf",     0, 8'hFE, 25'h1000000, 32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 1'b0, 2,  0);
        add_vec("shift2",        0, 8'h7F, 25'h0200000, 32'h3E800000, 32'h3E800000, 1'b0, 1'b0, 1'b0, 4,  1);
        add_vec("neg_zero",      1, 8'h55, 25'h0000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 2,  0);
        add_vec("shift_unf",     0, 8'h02, 25'h0000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 4,  0);
        add_vec("tie_odd",       0, 8'h7F, 25'h1000003, 32'h40000001, 32'h40000002, 1'b0, 1'b0, 1'b0, 2,  1);
        add_vec("tie_even",      0, 8'h7F, 25'h1000001, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 2,  1);
        add_vec("guard_zero",    0, 8'h7F, 25'h1000002, 32'h40000001, 32'h40000001, 1'b0, 1'b0, 1'b0, 2,  1);
        add_vec("nan_pass",      0, 8'hFF, 25'h0400001, 32'h7FC00001, 32'h7FC00001, 1'b0, 1'b0, 1'b0, 2,  0);
        add_vec("exp0_flush",    1, 8'h00, 25'h0800000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 2,  0);
        add_vec("neg_norm",      1, 8'h40, 25'h0C00000, 32'hA0400000, 32'hA0400000, 1'b0, 1'b0, 1'b0, 2,  1);
        add_vec("round_carry",   0, 8'h7F, 25'h1FFFFFF, 32'h407FFFFF, 32'h40800000, 1'b0, 1'b0, 1'b0, 2,  1);
        add_vec("round_ovf",     0, 8'hFD, 25'h1FFFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b0, 1'b1, 1'b0, 2,  1);
        add_vec("max_shift",     0, 8'h7F, 25'h0000001, 32'h34000000, 32'h34000000, 1'b0, 1'b0, 1'b0, 25, 1);
        add_vec("min_normal",    0, 8'h18, 25'h0000001, 32'h00800000, 32'h00800000, 1'b0, 1'b0, 1'b0, 25, 1);
        add_vec("deep_unf",      0, 8'h17, 25'h0000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 25, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_result",    bus.result,          32'h0);
        check("rst_done",      32'(bus.done),       32'd0);
        check("rst_busy",      32'(bus.busy),       32'd0);
        check("rst_overflow",  32'(bus.overflow),   32'd0);
        check("rst_underflow", 32'(bus.underflow),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: back-to-back operations, each started the cycle after the
        // previous done has cleared.
        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // Start while busy is ignored: one done, first operand's result.
        cnt_before = done_cnt;
        v = vecs[3];
        v.name = "busy_poke";
        run_op(v, 1'b1);
        repeat (10) @(negedge clk);
        check("poke_done_count", 32'(done_cnt - cnt_before), 32'd1);
        check("poke_result_held", bus.result, 32'h3E800000);

        // Result of the previous op stays put while a new op is in flight,
        // then reset mid-SHIFT clears everything immediately.
        cnt_before = done_cnt;
        @(negedge clk);
        bus.in_align = {2'b00, 1'b0, 8'h7F, 25'h0000001};
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before",   32'(bus.busy), 32'd1);
        check("abort_result_before", bus.result,    32'h3E800000);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_done",      32'(bus.done),      32'd0);
        check("abort_result",    bus.result,         32'h0);
        check("abort_overflow",  32'(bus.overflow),  32'd0);
        check("abort_underflow", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - cnt_before), 32'd0);
        check("abort_idle",    32'(bus.busy),              32'd0);

        // Recovery after the abort.
        run_op(vecs[0], 1'b0);
        run_op(vecs[6], 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
